// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
//   imem_req    : fetch request, valid for imem_addr
//   imem_addr   : byte address of the requested word
//   imem_ready  : memory accepts a request when req && ready
//   imem_rvalid : read data valid
//   imem_rdata  : instruction word
interface instr_fetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  // Fetch unit side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding a single-cycle control unit.
// Holds the PC, fetches one word per step over the imem bus, presents the
// instruction for one or more EXEC cycles, then updates the PC from the
// jump / Branch / zero signals returned by the control unit and ALU.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   imem          : instruction-memory bus (master side)
//   instr, opcode : current instruction and its [31:26] field (opcode comb.)
//   instr_valid   : high exactly in EXEC cycles
//   pc, pc_plus4  : current PC and PC+4 (pc_plus4 comb.)
//   Branch, jump, zero : next-PC controls, only used in EXEC
//   exec_stall    : holds EXEC
//   halted, fault : sticky terminal status
//   retired       : completed instruction count (wraps)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instr_fetch_unit_if.master         imem,
  output logic [31:0]                instr,
  output logic [5:0]                 opcode,
  output logic                       instr_valid,
  output logic [31:0]                pc,
  output logic [31:0]                pc_plus4,
  input  logic                       Branch,
  input  logic                       jump,
  input  logic                       zero,
  input  logic                       exec_stall,
  output logic                       halted,
  output logic                       fault,
  output logic [31:0]                retired
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] retired_q, retired_d;
  logic            instr_valid_q, instr_valid_d;
  logic            req_q, req_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;

  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] jump_target_c;
  logic [XLEN-1:0] branch_off_c;
  logic [XLEN-1:0] next_pc_c;

  // Next-PC candidates; all arithmetic wraps modulo 2^32
  always_comb begin
    pc_plus4_c    = pc_q + XLEN'(4);
    jump_target_c = {pc_plus4_c[31:28], instr_q[25:0], 2'b00};
    branch_off_c  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    if (jump) begin
      next_pc_c = jump_target_c;
    end else if (Branch && zero) begin
      next_pc_c = pc_plus4_c + branch_off_c;
    end else begin
      next_pc_c = pc_plus4_c;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = S_FAULT;
        end else if (imem.imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          instr_d = imem.imem_rdata;
          state_d = (imem.imem_rdata == HALT_WORD) ? S_HALT : S_EXEC;
        end
      end
      S_EXEC: begin
        if (!exec_stall) begin
          pc_d      = next_pc_c;
          retired_d = retired_q + XLEN'(1);
          state_d   = S_FETCH;
        end
      end
      S_HALT, S_FAULT: state_d = state_q;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the upcoming state;
    // a misaligned PC reports fault already in the FETCH cycle that sees it.
    req_d         = (state_d == S_FETCH) && (pc_d[1:0] == 2'b00);
    instr_valid_d = (state_d == S_EXEC);
    halted_d      = halted_q || (state_d == S_HALT);
    fault_d       = fault_q || ((state_d == S_FETCH) && (pc_d[1:0] != 2'b00));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      retired_q     <= '0;
      instr_valid_q <= 1'b0;
      req_q         <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      retired_q     <= retired_d;
      instr_valid_q <= instr_valid_d;
      req_q         <= req_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign opcode         = instr_q[XLEN-1 -: OPC_W];
  assign instr_valid    = instr_valid_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_plus4_c;
  assign halted         = halted_q;
  assign fault          = fault_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: main instance at RESET_PC=0, plus a
// misaligned-reset instance and an instance starting at 32'h1000_0000.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst2_n;
  logic br, jm, zr, stall;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  instr_fetch_unit_if bus1 ();
  instr_fetch_unit_if bus2 ();
  instr_fetch_unit_if bus3 ();

  logic [31:0] instr1, pc1, pcp1, ret1;
  logic [5:0]  opc1;
  logic        vld1, halted1, fault1;
  logic [31:0] instr2, pc2, pcp2, ret2;
  logic [5:0]  opc2;
  logic        vld2, halted2, fault2;
  logic [31:0] instr3, pc3, pcp3, ret3;
  logic [5:0]  opc3;
  logic        vld3, halted3, fault3;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .HALT_WORD(32'hFFFF_FFFF)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .imem(bus1),
    .instr(instr1), .opcode(opc1), .instr_valid(vld1), .pc(pc1), .pc_plus4(pcp1),
    .Branch(br), .jump(jm), .zero(zr), .exec_stall(stall),
    .halted(halted1), .fault(fault1), .retired(ret1)
  );

  instr_fetch_unit #(.RESET_PC(32'h0000_0002), .HALT_WORD(32'hFFFF_FFFF)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .imem(bus2),
    .instr(instr2), .opcode(opc2), .instr_valid(vld2), .pc(pc2), .pc_plus4(pcp2),
    .Branch(1'b0), .jump(1'b0), .zero(1'b0), .exec_stall(1'b0),
    .halted(halted2), .fault(fault2), .retired(ret2)
  );

  instr_fetch_unit #(.RESET_PC(32'h1000_0000), .HALT_WORD(32'hFFFF_FFFF)) u_dut3 (
    .clk(clk), .rst_n(rst2_n), .imem(bus3),
    .instr(instr3), .opcode(opc3), .instr_valid(vld3), .pc(pc3), .pc_plus4(pcp3),
    .Branch(1'b1), .jump(1'b1), .zero(1'b1), .exec_stall(1'b0),
    .halted(halted3), .fault(fault3), .retired(ret3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // One instruction step on dut1, starting at a negedge in its FETCH cycle
  task automatic step(input int rdy_lo, input int rv_lo, input int stall_n,
                      input logic [31:0] word, input logic b, input logic j, input logic z,
                      input logic [31:0] exp_pc, input logic [31:0] exp_next, input string tag,
                      output int ncyc, output int first_exec, output int nexec);
    int fc = 0;
    int wc = 0;
    int ec = 0;
    int phase = 0;
    ncyc = 0; first_exec = 0; nexec = 0;
    while (phase != 3 && ncyc < 64) begin
      case (phase)
        0: begin
          chk({tag, ".req"}, 32'(bus1.imem_req), 32'd1);
          chk({tag, ".addr"}, bus1.imem_addr, exp_pc);
          chk({tag, ".vld_f"}, 32'(vld1), 32'd0);
          bus1.imem_ready  = (fc >= rdy_lo);
          bus1.imem_rvalid = 1'b1;
          bus1.imem_rdata  = 32'hDEAD_BEEF;
          br = 1'b0; jm = 1'b0; zr = 1'b0; stall = 1'b0;
          if (bus1.imem_ready) phase = 1;
          fc++;
        end
        1: begin
          chk({tag, ".req_w"}, 32'(bus1.imem_req), 32'd0);
          chk({tag, ".vld_w"}, 32'(vld1), 32'd0);
          bus1.imem_ready  = 1'b0;
          bus1.imem_rvalid = (wc >= rv_lo);
          bus1.imem_rdata  = bus1.imem_rvalid ? word : 32'hBAD0_BAD0;
          if (bus1.imem_rvalid) phase = (word == 32'hFFFF_FFFF) ? 3 : 2;
          wc++;
        end
        default: begin
          if (ec == 0) first_exec = cyc;
          chk({tag, ".vld_e"}, 32'(vld1), 32'd1);
          chk({tag, ".instr"}, instr1, word);
          chk({tag, ".opcode"}, 32'(opc1), 32'(word[31:26]));
          chk({tag, ".pc_e"}, pc1, exp_pc);
          chk({tag, ".req_e"}, 32'(bus1.imem_req), 32'd0);
          bus1.imem_rvalid = 1'b1;
          bus1.imem_rdata  = 32'h1234_5678;
          stall = (ec < stall_n);
          br = b; jm = j; zr = z;
          if (!stall) phase = 3;
          ec++;
          nexec = ec;
        end
      endcase
      tick();
      ncyc++;
    end
    chk({tag, ".done"}, 32'(phase), 32'd3);
    br = 1'b0; jm = 1'b0; zr = 1'b0; stall = 1'b0;
    chk({tag, ".next_pc"}, pc1, exp_next);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fe, ne;
    rst_n = 1'b0; rst2_n = 1'b0;
    br = 1'b0; jm = 1'b0; zr = 1'b0; stall = 1'b0;
    bus1.imem_ready = 1'b0; bus1.imem_rvalid = 1'b0; bus1.imem_rdata = 32'h0;
    bus2.imem_ready = 1'b1; bus2.imem_rvalid = 1'b1; bus2.imem_rdata = 32'h0;
    bus3.imem_ready = 1'b1; bus3.imem_rvalid = 1'b1; bus3.imem_rdata = 32'h0800_0040;

    #12;
    chk("rst.pc", pc1, 32'h0);
    chk("rst.instr", instr1, 32'h0);
    chk("rst.vld", 32'(vld1), 32'd0);
    chk("rst.req", 32'(bus1.imem_req), 32'd0);
    chk("rst.halted", 32'(halted1), 32'd0);
    chk("rst.fault", 32'(fault1), 32'd0);
    chk("rst.retired", ret1, 32'h0);
    chk("rst.opcode", 32'(opc1), 32'd0);
    chk("rst.pc_plus4", pcp1, 32'h4);
    chk("rst.addr", bus1.imem_addr, 32'h0);

    @(negedge clk); rst_n = 1'b1; cyc = 0;
    tick();

    step(0, 0, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, "nop0", n, fe, ne);
    chk("nop0.cycles", 32'(n), 32'd3);
    chk("nop0.exec_cyc", 32'(fe), 32'd3);
    step(0, 0, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h4, 32'h8, "nop1", n, fe, ne);
    chk("nop1.exec_cyc", 32'(fe), 32'd6);
    chk("nop1.retired", ret1, 32'd2);

    step(0, 0, 0, 32'h0C00_0003, 1'b1, 1'b0, 1'b1, 32'h8, 32'd24, "beq_t", n, fe, ne);
    step(0, 0, 0, 32'h1000_FFFB, 1'b1, 1'b0, 1'b1, 32'd24, 32'h8, "beq_back", n, fe, ne);
    step(0, 0, 0, 32'h0C00_0003, 1'b1, 1'b0, 1'b0, 32'h8, 32'd12, "beq_nt", n, fe, ne);
    step(0, 0, 0, 32'h1000_FFFB, 1'b1, 1'b0, 1'b1, 32'd12, 32'hFFFF_FFFC, "beq_neg", n, fe, ne);
    step(0, 0, 0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, "wrap", n, fe, ne);
    chk("wrap.retired", ret1, 32'd7);

    step(2, 3, 2, 32'h2000_1234, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, "bp", n, fe, ne);
    chk("bp.cycles", 32'(n), 32'd10);
    chk("bp.exec_cnt", 32'(ne), 32'd3);
    chk("bp.retired", ret1, 32'd8);

    step(0, 0, 0, 32'h0800_0040, 1'b1, 1'b1, 1'b1, 32'h4, 32'h100, "jmp", n, fe, ne);
    chk("jmp.retired", ret1, 32'd9);

    step(0, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h100, 32'h100, "halt", n, fe, ne);
    chk("halt.halted", 32'(halted1), 32'd1);
    chk("halt.instr", instr1, 32'hFFFF_FFFF);
    chk("halt.retired", ret1, 32'd9);
    for (int i = 0; i < 5; i++) begin
      bus1.imem_ready = 1'b1; bus1.imem_rvalid = 1'b1; bus1.imem_rdata = 32'h0;
      chk("halt.req", 32'(bus1.imem_req), 32'd0);
      chk("halt.vld", 32'(vld1), 32'd0);
      chk("halt.sticky", 32'(halted1), 32'd1);
      chk("halt.pc", pc1, 32'h100);
      tick();
    end

    rst_n = 1'b0;
    #1;
    chk("rst2.halted", 32'(halted1), 32'd0);
    chk("rst2.pc", pc1, 32'h0);
    chk("rst2.retired", ret1, 32'h0);
    chk("rst2.instr", instr1, 32'h0);
    chk("rst2.req", 32'(bus1.imem_req), 32'd0);
    bus1.imem_ready = 1'b0; bus1.imem_rvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1; cyc = 0;
    tick();
    step(0, 0, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4, "again", n, fe, ne);
    chk("again.exec_cyc", 32'(fe), 32'd3);
    chk("again.retired", ret1, 32'd1);

    // Misaligned-reset and high-address jump instances
    @(negedge clk); rst2_n = 1'b1; cyc = 0;
    tick();
    chk("flt.fault_c1", 32'(fault2), 32'd1);
    chk("jhi.req_c1", 32'(bus3.imem_req), 32'd1);
    chk("jhi.addr_c1", bus3.imem_addr, 32'h1000_0000);
    for (int i = 0; i < 6; i++) begin
      chk("flt.req", 32'(bus2.imem_req), 32'd0);
      chk("flt.vld", 32'(vld2), 32'd0);
      chk("flt.fault", 32'(fault2), 32'd1);
      if (cyc == 3) begin
        chk("jhi.vld_c3", 32'(vld3), 32'd1);
        chk("jhi.opcode_c3", 32'(opc3), 32'd2);
        chk("jhi.instr_c3", instr3, 32'h0800_0040);
      end
      if (cyc == 4) begin
        chk("jhi.req_c4", 32'(bus3.imem_req), 32'd1);
        chk("jhi.addr_c4", bus3.imem_addr, 32'h1000_0100);
        chk("jhi.pc_plus4_c4", pcp3, 32'h1000_0104);
        chk("jhi.retired_c4", ret3, 32'd1);
        chk("jhi.flags_c4", {30'd0, halted3, fault3}, 32'd0);
      end
      tick();
    end
    chk("flt.pc", pc2, 32'h2);
    chk("flt.addr", bus2.imem_addr, 32'h2);
    chk("flt.pc_plus4", pcp2, 32'h6);
    chk("flt.instr", instr2, 32'h0);
    chk("flt.opcode", 32'(opc2), 32'd0);
    chk("flt.retired", ret2, 32'h0);
    chk("flt.halted", 32'(halted2), 32'd0);
    chk("jhi.pc_end", pc3, 32'h1000_0100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that sits directly upstream of the single-cycle control unit. It holds the program counter and fetches one 32-bit instruction per step over a request/response instruction-memory handshake. It presents the instruction and its opcode field to the control unit and datapath, then computes the next PC from the returned `Branch`, `jump` and ALU `zero` signals. It also tracks retired instructions and stops on halt or misaligned-PC fault.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset; must be word-aligned.
- `HALT_WORD`, default 32'hFFFF_FFFF: instruction encoding that stops fetching.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request, valid for address `imem_addr`.
- `imem_addr` out 32: byte address of the requested word (equals `pc`).
- `imem_ready` in 1: memory accepts the request in a cycle where `imem_req` and `imem_ready` are both high.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: registered current instruction.
- `opcode` out 6: `instr[31:26]`, which feeds the control unit.
- `instr_valid` out 1: `instr` is executing this cycle.
- `pc` out 32: address of the current or next instruction.
- `pc_plus4` out 32: `pc + 4`.
- `Branch` in 1: from the control unit; sampled only when `instr_valid` is high.
- `jump` in 1: from the control unit; sampled only when `instr_valid` is high.
- `zero` in 1: ALU zero flag; sampled only when `instr_valid` is high.
- `exec_stall` in 1: holds the EXEC state.
- `halted` out 1: sticky; set after a halt instruction.
- `fault` out 1: sticky; set after a misaligned PC.
- `retired` out 32: count of completed instructions.

## Operation
- FSM states: IDLE, FETCH, WAIT, EXEC, HALT, FAULT.
- IDLE: entered on reset. Moves to FETCH on the first clock after `rst_n` rises.
- FETCH:
  - If `pc[1:0] != 0`: go to FAULT and do not raise `imem_req`.
  - Otherwise `imem_req`=1 and `imem_addr`=`pc`. Stay in FETCH until `imem_ready`=1, then go to WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`=1:
  - Capture `imem_rdata` into `instr` and go to EXEC.
  - If `imem_rdata == HALT_WORD`, capture it, go to HALT and set `halted`. The halt word never asserts `instr_valid`.
- `imem_rvalid` outside WAIT is ignored. `imem_rdata` outside WAIT is ignored.
- EXEC: `instr_valid`=1.
  - If `exec_stall`=1: remain in EXEC. PC, `instr` and `retired` are unchanged.
  - Otherwise, at the clock edge: `pc` <= next PC, `retired` increments, go to FETCH.
- Next PC, evaluated in priority order:
  - `jump`=1: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - else `Branch`=1 and `zero`=1: `pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})`.
  - else: `pc_plus4`.
- Arithmetic:
  - All PC math is 32-bit, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
  - `retired` wraps from 32'hFFFF_FFFF to 0.
- HALT and FAULT are terminal. Only reset leaves them. Outputs are frozen and `imem_req`=0.
- FAULT is reachable only through a misaligned `RESET_PC`. Branch and jump targets are always word-aligned by construction.

## Timing
- Reset values (asynchronous):
  - `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `imem_req`=0.
  - `halted`=0, `fault`=0, `retired`=0, state IDLE.
- Reset asserted mid-operation: immediately force the reset values. Any in-flight memory response is dropped.
- `opcode`, `imem_addr` and `pc_plus4` are combinational from registers. Every other output is registered.
- Minimum step is 3 cycles per instruction (FETCH, WAIT, EXEC) when `imem_ready` and `imem_rvalid` are high on first opportunity.
- Each cycle `imem_ready` is low adds one FETCH cycle. Each cycle `imem_rvalid` is low adds one WAIT cycle.
- `instr_valid` is high exactly in EXEC cycles. The control unit and datapath outputs must settle within that cycle.
- New `pc` is visible in the cycle after the last EXEC cycle. That same cycle is the FETCH cycle, so `imem_req` carries the updated address.

## Test plan
- Reset with `RESET_PC`=0; memory returns 32'h0000_0000 then 32'h0000_0000, with ready and rvalid always high:
  - `instr_valid` pulses in cycles 3 and 6 after reset release.
  - `pc` reads 0 then 4.
  - `retired`=2 after the second EXEC.
- Branch: `instr`=32'h0C00_0003 at `pc`=8, with `Branch`=1 and `zero`=1 → next `pc`=24.
  - Same instruction with `zero`=0 → next `pc`=12.
- Jump: `instr`=32'h0800_0040 at `pc`=32'h1000_0000, with `jump`=1 and `Branch`=1 → next `pc`=32'h1000_0100 (jump wins).
- Backpressure: `imem_ready` low 2 cycles and `imem_rvalid` low 3 cycles, plus `exec_stall` high 2 cycles:
  - Step takes 10 cycles.
  - `imem_req` held stable until accepted.
  - `instr_valid` high 3 cycles.
  - `retired` +1.
- Halt: memory returns 32'hFFFF_FFFF:
  - `halted`=1 and `imem_req` stays 0.
  - `instr_valid` never asserts.
  - Reset pulse mid-HALT → returns to IDLE with `halted`=0.
- Wrap and fault:
  - At `pc`=32'hFFFF_FFFC with no branch or jump → next `pc`=0.
  - `RESET_PC`=32'h0000_0002 → `fault`=1 in the first FETCH cycle, and `imem_req` never asserts.
